// File: rtl/alarm_set_ctrl.sv
// Alarm-clock setting controller: edits the clock time or the alarm time,
// and handles stop/snooze of an active alarm.
module alarm_set_ctrl (
  input  logic       clock_1s,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  input  logic       Alarm,
  input  logic [1:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [1:0] hour_in1,
  output logic [3:0] hour_in0,
  output logic [3:0] minute_in1,
  output logic [3:0] minute_in0,
  output logic       load_time,
  output logic       load_alarm,
  output logic       STOP_alarm,
  output logic [2:0] state_out,
  output logic [1:0] snooze_cnt
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    EDIT_TIME  = 3'd1,
    EDIT_ALARM = 3'd2,
    COMMIT     = 3'd3,
    SNOOZE     = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic [4:0] edit_h_q, edit_h_d, alm_h_q, alm_h_d;
  logic [5:0] edit_m_q, edit_m_d, alm_m_q, alm_m_d;
  logic [1:0] snooze_q, snooze_d;
  logic       load_time_q, load_time_d, load_alarm_q, load_alarm_d;
  logic       stop_q, stop_d;
  logic [1:0] h1_q, h1_d;
  logic [3:0] h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;

  logic [4:0] cur_h, snz_h, out_h;
  logic [5:0] cur_m, snz_m, out_m;
  logic       load_bcd, alarm_req;
  logic [1:0] h_tens;
  logic [2:0] m_tens;
  logic [3:0] h_tens4, m_tens4;

  assign cur_h = ({3'b0, cur_hour1} * 5'd10) + {1'b0, cur_hour0};
  assign cur_m = ({2'b0, cur_min1} * 6'd10) + {2'b0, cur_min0};

  // Snooze target: current time plus five minutes, wrapping through midnight.
  always_comb begin
    if (cur_m >= 6'd55) begin
      snz_m = cur_m - 6'd55;
      snz_h = (cur_h == 5'd23) ? 5'd0 : cur_h + 5'd1;
    end else begin
      snz_m = cur_m + 6'd5;
      snz_h = cur_h;
    end
  end

  // The cycle right after a STOP pulse is ignored so a held button cannot
  // fire again before the clock core has dropped Alarm.
  assign alarm_req = Alarm && !stop_q && (btn_stop || btn_snooze);

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path infers a latch.
    state_d      = state_q;
    sel_d        = sel_q;
    edit_h_d     = edit_h_q;
    edit_m_d     = edit_m_q;
    alm_h_d      = alm_h_q;
    alm_m_d      = alm_m_q;
    snooze_d     = snooze_q;
    load_time_d  = 1'b0;
    load_alarm_d = 1'b0;
    stop_d       = 1'b0;
    load_bcd     = 1'b0;
    out_h        = edit_h_q;
    out_m        = edit_m_q;

    if (alarm_req) begin
      stop_d = 1'b1;
      if (!btn_stop && snooze_q != 2'd3) begin
        state_d      = SNOOZE;
        load_alarm_d = 1'b1;
        load_bcd     = 1'b1;
        out_h        = snz_h;
        out_m        = snz_m;
        alm_h_d      = snz_h;
        alm_m_d      = snz_m;
        snooze_d     = snooze_q + 2'd1;
      end else begin
        state_d  = IDLE;
        snooze_d = 2'd0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (btn_mode) begin
            state_d  = EDIT_TIME;
            edit_h_d = cur_h;
            edit_m_d = cur_m;
            sel_d    = 1'b0;
          end
        end
        EDIT_TIME, EDIT_ALARM: begin
          if (btn_mode) begin
            if (state_q == EDIT_TIME) begin
              state_d  = EDIT_ALARM;
              edit_h_d = alm_h_q;
              edit_m_d = alm_m_q;
              sel_d    = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else if (btn_set) begin
            if (!sel_q) begin
              sel_d = 1'b1;
            end else begin
              state_d  = COMMIT;
              load_bcd = 1'b1;
              if (state_q == EDIT_TIME) begin
                load_time_d = 1'b1;
              end else begin
                load_alarm_d = 1'b1;
                alm_h_d      = edit_h_q;
                alm_m_d      = edit_m_q;
              end
            end
          end else if (btn_inc) begin
            if (!sel_q) edit_h_d = (edit_h_q == 5'd23) ? 5'd0 : edit_h_q + 5'd1;
            else        edit_m_d = (edit_m_q == 6'd59) ? 6'd0 : edit_m_q + 6'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Binary to BCD by range compare; units are taken modulo 16, which is exact
  // because the true remainder is always below 10.
  always_comb begin
    if (out_h >= 5'd20)      h_tens = 2'd2;
    else if (out_h >= 5'd10) h_tens = 2'd1;
    else                     h_tens = 2'd0;
    if (out_m >= 6'd50)      m_tens = 3'd5;
    else if (out_m >= 6'd40) m_tens = 3'd4;
    else if (out_m >= 6'd30) m_tens = 3'd3;
    else if (out_m >= 6'd20) m_tens = 3'd2;
    else if (out_m >= 6'd10) m_tens = 3'd1;
    else                     m_tens = 3'd0;
    h_tens4 = {2'b0, h_tens};
    m_tens4 = {1'b0, m_tens};
    h1_d = h1_q;
    h0_d = h0_q;
    m1_d = m1_q;
    m0_d = m0_q;
    if (load_bcd) begin
      h1_d = h_tens;
      h0_d = out_h[3:0] - ((h_tens4 << 3) + (h_tens4 << 1));
      m1_d = m_tens4;
      m0_d = out_m[3:0] - ((m_tens4 << 3) + (m_tens4 << 1));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_1s or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      edit_h_q     <= 5'd0;
      edit_m_q     <= 6'd0;
      alm_h_q      <= 5'd0;
      alm_m_q      <= 6'd0;
      snooze_q     <= 2'd0;
      load_time_q  <= 1'b0;
      load_alarm_q <= 1'b0;
      stop_q       <= 1'b0;
      h1_q         <= 2'd0;
      h0_q         <= 4'd0;
      m1_q         <= 4'd0;
      m0_q         <= 4'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      edit_h_q     <= edit_h_d;
      edit_m_q     <= edit_m_d;
      alm_h_q      <= alm_h_d;
      alm_m_q      <= alm_m_d;
      snooze_q     <= snooze_d;
      load_time_q  <= load_time_d;
      load_alarm_q <= load_alarm_d;
      stop_q       <= stop_d;
      h1_q         <= h1_d;
      h0_q         <= h0_d;
      m1_q         <= m1_d;
      m0_q         <= m0_d;
    end
  end

  assign hour_in1   = h1_q;
  assign hour_in0   = h0_q;
  assign minute_in1 = m1_q;
  assign minute_in0 = m0_q;
  assign load_time  = load_time_q;
  assign load_alarm = load_alarm_q;
  assign STOP_alarm = stop_q;
  assign state_out  = state_q;
  assign snooze_cnt = snooze_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Bench for alarm_set_ctrl: directed scenarios plus randomized traffic checked
// against a minute-of-day reference model.
module tb_alarm_set_ctrl;

  logic       clock_1s = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_set = 1'b0;
  logic       btn_snooze = 1'b0, btn_stop = 1'b0, Alarm = 1'b0;
  logic [1:0] cur_hour1 = 2'd0;
  logic [3:0] cur_hour0 = 4'd0, cur_min1 = 4'd0, cur_min0 = 4'd0;
  logic [1:0] hour_in1;
  logic [3:0] hour_in0, minute_in1, minute_in0;
  logic       load_time, load_alarm, STOP_alarm;
  logic [2:0] state_out;
  logic [1:0] snooze_cnt;

  int compared = 0;
  int failed = 0;

  // Reference model: states as plain ints, times as hour/minute integers.
  int cur_h = 0, cur_m = 0;
  int m_state, m_sel, m_eh, m_em, m_ah, m_am, m_cnt, m_oh, m_om;
  bit m_lt, m_la, m_stop;

  alarm_set_ctrl dut (
    .clock_1s  (clock_1s),
    .reset     (reset),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_set   (btn_set),
    .btn_snooze(btn_snooze),
    .btn_stop  (btn_stop),
    .Alarm     (Alarm),
    .cur_hour1 (cur_hour1),
    .cur_hour0 (cur_hour0),
    .cur_min1  (cur_min1),
    .cur_min0  (cur_min0),
    .hour_in1  (hour_in1),
    .hour_in0  (hour_in0),
    .minute_in1(minute_in1),
    .minute_in0(minute_in0),
    .load_time (load_time),
    .load_alarm(load_alarm),
    .STOP_alarm(STOP_alarm),
    .state_out (state_out),
    .snooze_cnt(snooze_cnt)
  );

  always #5 clock_1s = ~clock_1s;

  task automatic model_reset();
    m_state = 0; m_sel = 0; m_eh = 0; m_em = 0; m_ah = 0; m_am = 0;
    m_cnt = 0; m_oh = 0; m_om = 0; m_lt = 0; m_la = 0; m_stop = 0;
  endtask

  task automatic model_step(bit md, bit inc, bit st, bit snz, bit stp, bit alm);
    bit prev_stop;
    int t;
    prev_stop = m_stop;
    m_lt = 0; m_la = 0; m_stop = 0;
    if (alm && !prev_stop && (stp || snz)) begin
      m_stop = 1;
      if (!stp && m_cnt < 3) begin
        t = (cur_h * 60 + cur_m + 5) % 1440;
        m_oh = t / 60; m_om = t % 60;
        m_ah = m_oh; m_am = m_om;
        m_cnt++; m_la = 1; m_state = 4;
      end else begin
        m_cnt = 0; m_state = 0;
      end
    end else if (m_state == 1 || m_state == 2) begin
      if (md) begin
        if (m_state == 1) begin m_state = 2; m_eh = m_ah; m_em = m_am; m_sel = 0; end
        else m_state = 0;
      end else if (st) begin
        if (m_sel == 0) m_sel = 1;
        else begin
          m_oh = m_eh; m_om = m_em;
          if (m_state == 1) m_lt = 1;
          else begin m_la = 1; m_ah = m_eh; m_am = m_em; end
          m_state = 3;
        end
      end else if (inc) begin
        if (m_sel == 0) m_eh = (m_eh + 1) % 24;
        else m_em = (m_em + 1) % 60;
      end
    end else if (m_state == 0) begin
      if (md) begin m_state = 1; m_eh = cur_h; m_em = cur_m; m_sel = 0; end
    end else begin
      m_state = 0;
    end
  endtask

  task automatic set_cur(int h, int m);
    cur_h = h; cur_m = m;
    cur_hour1 = 2'(h / 10); cur_hour0 = 4'(h % 10);
    cur_min1  = 4'(m / 10); cur_min0  = 4'(m % 10);
  endtask

  // Drive one cycle of buttons, clock it, advance the model, settle 1 time unit.
  task automatic step(bit md, bit inc, bit st, bit snz, bit stp, bit alm);
    btn_mode = md; btn_inc = inc; btn_set = st;
    btn_snooze = snz; btn_stop = stp; Alarm = alm;
    @(posedge clock_1s);
    model_step(md, inc, st, snz, stp, alm);
    #1;
  endtask

  function automatic logic [13:0] digits();
    return {hour_in1, hour_in0, minute_in1, minute_in0};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clock_1s);
    #1;
    compared++; if (state_out !== 3'd0 || snooze_cnt !== 2'd0) begin failed++;
      $display("FAIL reset_state got st=%0d cnt=%0d want 0/0", state_out, snooze_cnt); end
    compared++; if (digits() !== 14'h0 || {load_time, load_alarm, STOP_alarm} !== 3'b000) begin failed++;
      $display("FAIL reset_outputs got digits=%h pulses=%b want 0/000", digits(), {load_time, load_alarm, STOP_alarm}); end
    reset = 1'b0;
  endtask

  task automatic test_time_entry();
    set_cur(12, 34);
    step(1, 0, 0, 0, 0, 0);
    compared++; if (state_out !== 3'd1) begin failed++;
      $display("FAIL time_enter state got %0d want 1", state_out); end
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (2) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    compared++; if (state_out !== 3'd3 || load_time !== 1'b1 || load_alarm !== 1'b0) begin failed++;
      $display("FAIL time_commit got st=%0d lt=%b la=%b want 3/1/0", state_out, load_time, load_alarm); end
    compared++; if (digits() !== {2'd1, 4'd5, 4'd3, 4'd6}) begin failed++;
      $display("FAIL time_digits got %h want 1536", digits()); end
    step(0, 0, 0, 0, 0, 0);
    compared++; if (state_out !== 3'd0 || load_time !== 1'b0 || digits() !== {2'd1, 4'd5, 4'd3, 4'd6}) begin failed++;
      $display("FAIL time_after got st=%0d lt=%b digits=%h want 0/0/1536", state_out, load_time, digits()); end
  endtask

  task automatic test_alarm_entry();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    compared++; if (state_out !== 3'd2 || load_time !== 1'b0) begin failed++;
      $display("FAIL alarm_enter got st=%0d lt=%b want 2/0", state_out, load_time); end
    repeat (24) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    repeat (61) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    compared++; if (load_alarm !== 1'b1 || load_time !== 1'b0 || digits() !== 14'h0001) begin failed++;
      $display("FAIL alarm_commit got la=%b lt=%b digits=%h want 1/0/0001", load_alarm, load_time, digits()); end
    step(0, 0, 0, 0, 0, 0);
    // Abandoned alarm edit: no pulse, outputs unchanged.
    step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0);
    compared++; if (state_out !== 3'd0 || load_alarm !== 1'b0 || digits() !== 14'h0001) begin failed++;
      $display("FAIL alarm_discard got st=%0d la=%b digits=%h want 0/0/0001", state_out, load_alarm, digits()); end
    // Shadow readback: commit an unmodified alarm edit.
    step(1, 0, 0, 0, 0, 0); step(1, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    compared++; if (load_alarm !== 1'b1 || digits() !== 14'h0001) begin failed++;
      $display("FAIL alarm_shadow got la=%b digits=%h want 1/0001", load_alarm, digits()); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_snooze_wrap();
    set_cur(23, 57);
    step(0, 0, 0, 1, 0, 1);
    compared++; if ({STOP_alarm, load_alarm, load_time} !== 3'b110 || state_out !== 3'd4) begin failed++;
      $display("FAIL snooze_pulses got sal=%b st=%0d want 110/4", {STOP_alarm, load_alarm, load_time}, state_out); end
    compared++; if (digits() !== 14'h0002 || snooze_cnt !== 2'd1) begin failed++;
      $display("FAIL snooze_value got digits=%h cnt=%0d want 0002/1", digits(), snooze_cnt); end
    repeat (2) begin
      step(0, 0, 0, 1, 0, 0);
      compared++; if ({STOP_alarm, load_alarm} !== 2'b00 || state_out !== 3'd0 || snooze_cnt !== 2'd1) begin failed++;
        $display("FAIL snooze_held got sl=%b st=%0d cnt=%0d want 00/0/1", {STOP_alarm, load_alarm}, state_out, snooze_cnt); end
    end
  endtask

  task automatic test_snooze_limit();
    step(0, 0, 0, 0, 1, 1);
    compared++; if (STOP_alarm !== 1'b1 || load_alarm !== 1'b0 || snooze_cnt !== 2'd0) begin failed++;
      $display("FAIL stop_clear got s=%b la=%b cnt=%0d want 1/0/0", STOP_alarm, load_alarm, snooze_cnt); end
    step(0, 0, 0, 0, 0, 0);
    set_cur(10, 0);
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 1, 0, 1);
      compared++; if (load_alarm !== 1'b1 || snooze_cnt !== 2'(i)) begin failed++;
        $display("FAIL snooze_n%0d got la=%b cnt=%0d want 1/%0d", i, load_alarm, snooze_cnt, i); end
      step(0, 0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1, 0, 1);
    compared++; if ({STOP_alarm, load_alarm} !== 2'b10 || snooze_cnt !== 2'd0 || state_out !== 3'd0) begin failed++;
      $display("FAIL snooze_limit got sl=%b cnt=%0d st=%0d want 10/0/0", {STOP_alarm, load_alarm}, snooze_cnt, state_out); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_preempt();
    set_cur(8, 15);
    step(1, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1);
    compared++; if ({STOP_alarm, load_alarm, load_time} !== 3'b100 || state_out !== 3'd0) begin failed++;
      $display("FAIL preempt got sal=%b st=%0d want 100/0", {STOP_alarm, load_alarm, load_time}, state_out); end
    step(0, 0, 1, 0, 0, 0);
    compared++; if (state_out !== 3'd0 || load_time !== 1'b0 || STOP_alarm !== 1'b0) begin failed++;
      $display("FAIL preempt_after got st=%0d lt=%b s=%b want 0/0/0", state_out, load_time, STOP_alarm); end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    compared++; if (state_out !== 3'd2 || load_time !== 1'b0) begin failed++;
      $display("FAIL prio_mode got st=%0d lt=%b want 2/0", state_out, load_time); end
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    compared++; if (load_alarm !== 1'b1 || digits() !== {2'd1, 4'd0, 4'd0, 4'd5}) begin failed++;
      $display("FAIL prio_set got la=%b digits=%h want 1/1005", load_alarm, digits()); end
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset_commit();
    set_cur(7, 42);
    step(1, 0, 0, 0, 0, 0); step(0, 0, 1, 0, 0, 0); step(0, 0, 1, 0, 0, 0);
    compared++; if (load_time !== 1'b1 || state_out !== 3'd3) begin failed++;
      $display("FAIL rc_commit got lt=%b st=%0d want 1/3", load_time, state_out); end
    reset = 1'b1;
    model_reset();
    #1;
    compared++; if ({load_time, load_alarm, STOP_alarm} !== 3'b000 || digits() !== 14'h0 || state_out !== 3'd0) begin failed++;
      $display("FAIL rc_async got pulses=%b digits=%h st=%0d want 000/0/0", {load_time, load_alarm, STOP_alarm}, digits(), state_out); end
    #2 reset = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    compared++; if ({load_time, load_alarm, STOP_alarm} !== 3'b000 || digits() !== 14'h0 || state_out !== 3'd0) begin failed++;
      $display("FAIL rc_after got pulses=%b digits=%h st=%0d want 000/0/0", {load_time, load_alarm, STOP_alarm}, digits(), state_out); end
  endtask

  task automatic test_random();
    logic [22:0] got, want;
    for (int n = 0; n < 600; n++) begin
      set_cur(int'($urandom_range(23)), int'($urandom_range(59)));
      step($urandom_range(99) < 12, $urandom_range(99) < 45, $urandom_range(99) < 15,
           $urandom_range(99) < 10, $urandom_range(99) < 5, $urandom_range(99) < 25);
      got  = {state_out, load_time, load_alarm, STOP_alarm, snooze_cnt, digits()};
      want = {3'(m_state), m_lt, m_la, m_stop, 2'(m_cnt),
              2'(m_oh / 10), 4'(m_oh % 10), 4'(m_om / 10), 4'(m_om % 10)};
      compared++; if (got !== want) begin failed++;
        $display("FAIL random_%0d got %h want %h", n, got, want); end
      compared++; if ((load_time & load_alarm) !== 1'b0) begin failed++;
        $display("FAIL random_excl_%0d got lt=%b la=%b want not both", n, load_time, load_alarm); end
    end
  endtask

  initial begin
    set_cur(0, 0);
    test_reset();
    test_time_entry();
    test_alarm_entry();
    test_snooze_wrap();
    test_snooze_limit();
    test_preempt();
    test_priority();
    test_reset_commit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/alarm_set_ctrl.md
ALARM_SET_CTRL -- requirements
Module: alarm_set_ctrl

Interface
REQ-001 The block SHALL have these ports: reset, asynchronous, active-high; clock clock_1s.
- reset  in  1  asynchronous active-high reset
- clock_1s  in  1  1 Hz system tick; all state changes on its rising edge
- btn_mode  in  1  level; cycles IDLE -> EDIT_TIME -> EDIT_ALARM -> IDLE
- btn_inc  in  1  level; increments the selected field once per cycle while high
- btn_set  in  1  level; confirms the selected field and advances to the next field
- btn_snooze  in  1  level; snoozes an active alarm
- btn_stop  in  1  level; silences an active alarm
- Alarm  in  1  alarm-active flag from the clock core
- cur_hour1 [1:0], cur_hour0 [3:0], cur_min1 [3:0], cur_min0 [3:0]  in  current time as BCD digits
- hour_in1 [1:0], hour_in0 [3:0], minute_in1 [3:0], minute_in0 [3:0]  out  BCD load value
- load_time  out  1  one-cycle pulse that loads the clock time
- load_alarm  out  1  one-cycle pulse that loads the alarm time
- STOP_alarm  out  1  one-cycle pulse that clears Alarm
- state_out [2:0]  out  encoded FSM state for display
- snooze_cnt [1:0]  out  number of snoozes taken in the current alarm episode

Function
REQ-002 FSM states SHALL be IDLE=0, EDIT_TIME=1, EDIT_ALARM=2, COMMIT=3, SNOOZE=4.
REQ-003 The block SHALL hold the edit value as binary registers: edit_h (0-23, 5 bits) and edit_m (0-59, 6 bits), plus a field select sel (0=hour, 1=minute).
REQ-004 IDLE with btn_mode=1 SHALL go to EDIT_TIME, load edit_h/edit_m from the cur_* digits (tens*10+units), and set sel=0.
REQ-005 EDIT_TIME with btn_mode=1 SHALL go to EDIT_ALARM, load edit_h/edit_m from the alarm shadow register, set sel=0, and issue no load pulse.
REQ-006 EDIT_ALARM with btn_mode=1 SHALL return to IDLE, discard the edit, and issue no pulse.
REQ-007 In an edit state, btn_inc=1 SHALL increment the selected field by 1. edit_h wraps 23->0 and edit_m wraps 59->0; there is no carry between fields.
REQ-008 In an edit state, btn_set=1 with sel=0 SHALL set sel=1; with sel=1 it SHALL go to COMMIT.
REQ-009 btn_mode SHALL take priority over btn_set, and btn_set over btn_inc, when they are asserted in the same cycle.
REQ-010 COMMIT SHALL last exactly one cycle.
- Drives the BCD outputs from edit_h/edit_m.
- Asserts load_time (if entered from EDIT_TIME) or load_alarm (if entered from EDIT_ALARM).
- On load_alarm, copies the edit value to the alarm shadow register.
- Returns to IDLE.
REQ-011 The BCD outputs SHALL be registered and hold their last driven value between pulses; tens=value/10 and units=value%10, with no division operator.
REQ-012 When Alarm=1 and btn_stop=1 (any state), the block SHALL pulse STOP_alarm for one cycle and clear snooze_cnt.
REQ-013 When Alarm=1, btn_snooze=1, btn_stop=0 and snooze_cnt<3, the block SHALL go to SNOOZE.
REQ-014 When Alarm=1, btn_snooze=1, btn_stop=0 and snooze_cnt=3, the block SHALL treat the snooze as a stop per REQ-012.
REQ-015 SNOOZE SHALL last one cycle and then return to IDLE.
- Pulses STOP_alarm and load_alarm together.
- Output time = current time + 5 min; minutes wrap 55..59 -> 0..4 with hour+1, and hour wraps 23->0.
- Updates the alarm shadow register with the new time and increments snooze_cnt.
REQ-016 An Alarm-driven action (REQ-012..015) SHALL preempt any edit state, abandon the edit, and leave the FSM in IDLE afterwards.
REQ-017 load_time, load_alarm and STOP_alarm SHALL each be high for at most one cycle per triggering event, and load_time and load_alarm SHALL never be high together.
REQ-018 A held btn_snooze or btn_stop SHALL NOT retrigger while Alarm=0.

Reset
REQ-019 Reset SHALL force, immediately and asynchronously:
- state=IDLE, sel=0, edit_h=edit_m=0
- alarm shadow = 00:00, snooze_cnt=0
- all BCD outputs 0, and load_time, load_alarm, STOP_alarm low
REQ-020 Reset asserted mid-edit or in COMMIT/SNOOZE SHALL suppress any pending pulse.

Verification
REQ-021 Time entry: cur=12:34; sequence mode, inc x3, set, inc x2, set -> one-cycle load_time with outputs 1,5,3,6; load_alarm stays 0.
REQ-022 Alarm entry with wrap: enter EDIT_ALARM from shadow 00:00; inc x24 on hours, set, inc x61 on minutes, set -> load_alarm with 0,0,0,1; shadow = 00:01.
REQ-023 Snooze wrap: Alarm=1, cur=23:57, btn_snooze -> STOP_alarm and load_alarm in the same cycle, outputs 0,0,0,2, snooze_cnt=1.
REQ-024 Snooze limit: three snoozes, then a fourth btn_snooze with Alarm=1 -> STOP_alarm only, no load_alarm, snooze_cnt=0.
REQ-025 Preemption/priority: in EDIT_TIME with sel=1, Alarm=1 with btn_stop=btn_snooze=1 -> STOP_alarm only; state IDLE next cycle; no load_time.
REQ-026 Reset mid-COMMIT: reset asserted in the COMMIT cycle -> no load pulse; all outputs 0; state IDLE.
